// File: rtl/uart_msg_formatter.sv
// uart_msg_formatter
//   Turns a result value or an error code into an ASCII text message, one
//   character per valid/ready handshake, for a byte FIFO or UART transmitter.
//     error_in == 0 : "Result: " <hex digits> <terminator>
//     error_in != 0 : "Error: " <hex digits> "!" <terminator>
//   The terminator is CR LF when CRLF_EN=1 and LF alone when CRLF_EN=0.
//   Hex digits are uppercase. With SUPPRESS_ZEROS=1, leading zero result
//   digits are dropped, but the last digit is always sent.
//   A request is captured in IDLE. LOAD works out the message shape, and
//   SEND streams the characters out.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   request present on data_in / error_in
//   in_ready   request is accepted this cycle (high only in IDLE)
//   data_in    result value, most significant nibble first
//   error_in   error code; a nonzero value selects the error message
//   out_valid  out_byte holds a character (high throughout SEND)
//   out_ready  downstream takes out_byte this cycle
//   out_byte   ASCII character, 0x00 outside SEND
//   out_last   out_byte is the final LF of the message
//   msg_count  number of completed messages, wraps at 16 bits
module uart_msg_formatter #(
  parameter int RESULT_DIGITS  = 4,
  parameter int ERROR_WIDTH    = 2,
  parameter int SUPPRESS_ZEROS = 0,
  parameter int CRLF_EN        = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [RESULT_DIGITS*4-1:0] data_in,
  input  logic [ERROR_WIDTH-1:0]     error_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_byte,
  output logic                       out_last,
  output logic [15:0]                msg_count
);

  localparam int ERR_DIGITS = (ERROR_WIDTH + 3) / 4;
  localparam int TERM_LEN   = (CRLF_EN != 0) ? 2 : 1;
  localparam int RES_PREFIX = 8;
  localparam int ERR_PREFIX = 7;
  localparam logic [8*RES_PREFIX-1:0] RES_STR = "Result: ";
  localparam logic [8*ERR_PREFIX-1:0] ERR_STR = "Error: ";

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t                     state, state_next;
  logic [RESULT_DIGITS*4-1:0] data_q;
  logic [ERROR_WIDTH-1:0]     err_q;
  logic [4*ERR_DIGITS-1:0]    err_ext;
  logic [4:0]                 idx;       // position within the message
  logic [4:0]                 last_idx;  // position of the final LF
  logic [4:0]                 last_n;
  logic [3:0]                 lead_q;    // leading result digits to skip
  logic [3:0]                 lead_n;
  logic                       is_err;
  logic                       accept;
  logic                       advance;
  logic                       final_hs;
  int                         pos;

  assign is_err   = |err_q;
  assign accept   = (state == IDLE) && in_valid;
  assign advance  = (state == SEND) && out_ready;
  assign final_hs = advance && (idx == last_idx);

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // State register, character index and message counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register here samples the values from before the edge.
      state     <= IDLE;
      idx       <= '0;
      msg_count <= '0;
    end else begin
      state <= state_next;
      if (final_hs) begin
        idx       <= '0;
        msg_count <= msg_count + 16'd1;
      end else if (advance) begin
        idx <= idx + 5'd1;
      end
    end
  end

  // Captured request and the message shape worked out during LOAD.
  // NOTE: these registers have no reset. They are written before SEND can
  // read them, so resetting them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= data_in;
      err_q  <= error_in;
    end
    if (state == LOAD) begin
      lead_q   <= lead_n;
      last_idx <= last_n;
    end
  end

  // Count the leading zero nibbles, stopping at the first nonzero nibble.
  // The least significant digit is never counted, so at least one digit
  // is always sent.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so the block cannot infer a latch.
    lead_n = '0;
    if (SUPPRESS_ZEROS != 0) begin
      for (int d = 0; d < RESULT_DIGITS - 1; d++) begin
        if (int'(lead_n) == d && data_q[4*(RESULT_DIGITS-1-d) +: 4] == 4'h0)
          lead_n = lead_n + 4'd1;
      end
    end
  end

  always_comb begin
    if (is_err)
      last_n = 5'(ERR_PREFIX + ERR_DIGITS + 1 + TERM_LEN - 1);
    else
      last_n = 5'(RES_PREFIX + RESULT_DIGITS - int'(lead_n) + TERM_LEN - 1);
  end

  // Zero-extend the error code to a whole number of nibbles.
  always_comb begin
    err_ext                    = '0;
    err_ext[ERROR_WIDTH-1:0]   = err_q;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    if (final_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: the character is a pure function of idx and the
  // captured request, so it holds steady while out_ready is low.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_byte  = 8'h00;
    pos       = int'(idx);
    if (state == SEND) begin
      out_valid = 1'b1;
      out_last  = (idx == last_idx);
      if (is_err) begin
        if (pos < ERR_PREFIX)
          out_byte = ERR_STR[8*(ERR_PREFIX-1-pos) +: 8];
        else if (pos < ERR_PREFIX + ERR_DIGITS)
          out_byte = hex_char(err_ext[4*(ERR_DIGITS-1-(pos-ERR_PREFIX)) +: 4]);
        else if (pos == ERR_PREFIX + ERR_DIGITS)
          out_byte = 8'h21;
        else
          out_byte = out_last ? 8'h0A : 8'h0D;
      end else begin
        if (pos < RES_PREFIX)
          out_byte = RES_STR[8*(RES_PREFIX-1-pos) +: 8];
        else if (pos < RES_PREFIX + RESULT_DIGITS - int'(lead_q))
          out_byte = hex_char(
            data_q[4*(RESULT_DIGITS-1-int'(lead_q)-(pos-RES_PREFIX)) +: 4]);
        else
          out_byte = out_last ? 8'h0A : 8'h0D;
      end
    end
  end

endmodule

// File: tb/tb_uart_msg_formatter.sv
// Testbench for uart_msg_formatter. It uses three instances:
//   a: default parameters
//   b: SUPPRESS_ZEROS=1
//   c: RESULT_DIGITS=8, ERROR_WIDTH=5, CRLF_EN=0
// A text-level model builds each expected message as a string from the
// request. One negedge process compares every output of every instance
// against that model on every cycle after reset.
module tb_uart_msg_formatter;

  localparam int P_RD [3] = '{4, 4, 8};
  localparam int P_EW [3] = '{2, 2, 5};
  localparam int P_SZ [3] = '{0, 1, 0};
  localparam int P_CR [3] = '{1, 1, 0};

  logic        clk = 1'b0;
  logic [2:0]  rst;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [31:0] d_in [3];
  logic [15:0] e_in [3];
  wire  [2:0]  in_ready;
  wire  [2:0]  out_valid;
  wire  [2:0]  out_last;
  wire  [7:0]  out_byte [3];
  wire  [15:0] mc [3];

  int    n_cmp = 0;
  int    n_err = 0;
  string nm [3] = '{"a", "b", "c"};

  // Model state, advanced once per clock.
  int          phase [3];  // 0 idle, 1 load, 2 send
  int          pos   [3];
  logic [15:0] cnt   [3];
  string       cur   [3];
  string       rx    [3];  // bytes the DUT handed over
  bit          known [3];
  int          vcnt  [3];
  bit          rmode [3];  // random out_ready stalls

  string crlf_s, lf_s;

  always #5 clk = ~clk;

  uart_msg_formatter u_dut_a (
    .clk(clk), .reset(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(d_in[0][15:0]), .error_in(e_in[0][1:0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_byte(out_byte[0]), .out_last(out_last[0]),
    .msg_count(mc[0]));

  uart_msg_formatter #(.SUPPRESS_ZEROS(1)) u_dut_b (
    .clk(clk), .reset(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(d_in[1][15:0]), .error_in(e_in[1][1:0]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_byte(out_byte[1]), .out_last(out_last[1]),
    .msg_count(mc[1]));

  uart_msg_formatter #(.RESULT_DIGITS(8), .ERROR_WIDTH(5), .CRLF_EN(0)) u_dut_c (
    .clk(clk), .reset(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .data_in(d_in[2]), .error_in(e_in[2][4:0]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_byte(out_byte[2]), .out_last(out_last[2]),
    .msg_count(mc[2]));

  function automatic string chr(input logic [7:0] b);
    string t;
    t = " ";
    t[0] = b;
    return t;
  endfunction

  function automatic string hexify(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h ", s[i])};
    return r;
  endfunction

  // Text-level model of one message.
  function automatic string expect_msg(input int rd, input int ew, input int sz,
                                       input int crlf, input logic [31:0] d,
                                       input logic [15:0] e);
    string s, h;
    int ed;
    logic [63:0] em, dm;
    em = {48'h0, e} & ((64'd1 << ew) - 64'd1);
    ed = (ew + 3) / 4;
    if (em != 64'd0) begin
      h = $sformatf("%04h", em[15:0]);
      h = h.toupper();
      s = {"Error: ", h.substr(4 - ed, 3), "!"};
    end else begin
      dm = {32'h0, d} & ((64'd1 << (4 * rd)) - 64'd1);
      h = $sformatf("%08h", dm[31:0]);
      h = h.toupper();
      h = h.substr(8 - rd, 7);
      if (sz != 0)
        while (h.len() > 1 && h[0] == 8'h30) h = h.substr(1, h.len() - 1);
      s = {"Result: ", h};
    end
    if (crlf != 0) s = {s, chr(8'h0D), chr(8'h0A)};
    else           s = {s, chr(8'h0A)};
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got [%s] expected [%s]", name, hexify(act), hexify(exp));
    end
  endtask

  // Compare process: check the outputs of this cycle, then advance the model
  // to the state the next rising edge produces.
  initial begin
    for (int k = 0; k < 3; k++) begin
      known[k] = 0; phase[k] = 0; pos[k] = 0; cnt[k] = '0;
      cur[k] = ""; rx[k] = ""; vcnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (known[k]) begin
          check($sformatf("%s.in_ready", nm[k]), 32'(in_ready[k]), 32'(phase[k] == 0));
          check($sformatf("%s.out_valid", nm[k]), 32'(out_valid[k]), 32'(phase[k] == 2));
          if (phase[k] == 2) begin
            check($sformatf("%s.byte%0d", nm[k], pos[k]), 32'(out_byte[k]),
                  32'(cur[k][pos[k]]));
            check($sformatf("%s.last%0d", nm[k], pos[k]), 32'(out_last[k]),
                  32'(pos[k] == cur[k].len() - 1));
          end else begin
            check($sformatf("%s.idle_byte", nm[k]), 32'(out_byte[k]), 32'h0);
            check($sformatf("%s.idle_last", nm[k]), 32'(out_last[k]), 32'h0);
          end
          check($sformatf("%s.msg_count", nm[k]), 32'(mc[k]), 32'(cnt[k]));
        end
        if (out_valid[k] === 1'b1) vcnt[k]++;
        if (rst[k]) begin
          known[k] = 1; phase[k] = 0; pos[k] = 0; cnt[k] = '0;
        end else if (known[k]) begin
          case (phase[k])
            0: if (in_valid[k]) begin
                 cur[k] = expect_msg(P_RD[k], P_EW[k], P_SZ[k], P_CR[k], d_in[k], e_in[k]);
                 phase[k] = 1;
               end
            1: begin phase[k] = 2; pos[k] = 0; end
            default:
              if (out_ready[k]) begin
                rx[k] = {rx[k], chr(out_byte[k])};
                if (pos[k] == cur[k].len() - 1) begin
                  phase[k] = 0;
                  cnt[k]   = cnt[k] + 16'd1;
                end else begin
                  pos[k]++;
                end
              end
          endcase
        end
      end
    end
  end

  // out_ready source: held high, or random per cycle when stalls are enabled.
  initial begin
    out_ready = 3'b111;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
        out_ready[k] = rmode[k] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Present a request for one cycle, then scramble the inputs so that a
  // message built from the live inputs instead of the captured ones differs.
  task automatic start_req(input int k, input logic [31:0] d, input logic [15:0] e);
    @(posedge clk); #1;
    in_valid[k] = 1'b1; d_in[k] = d; e_in[k] = e;
    @(posedge clk); #1;
    in_valid[k] = 1'b0; d_in[k] = $urandom; e_in[k] = 16'($urandom);
  endtask

  task automatic wait_done(input int k);
    bit done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk); #1;
      if (out_valid[k] && out_ready[k] && out_last[k]) done = 1;
    end
    check($sformatf("%s.done_in_time", nm[k]), 32'(done), 32'h1);
  endtask

  task automatic run_msg(input int k, input logic [31:0] d, input logic [15:0] e,
                         input string lit);
    rx[k] = "";
    start_req(k, d, e);
    wait_done(k);
    check_str($sformatf("%s.text_%0h_%0h", nm[k], d, e), rx[k], lit);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got5;
    crlf_s = {chr(8'h0D), chr(8'h0A)};
    lf_s   = chr(8'h0A);
    rmode  = '{0, 0, 0};
    rst = 3'b111; in_valid = 3'b000;
    for (int k = 0; k < 3; k++) begin d_in[k] = '0; e_in[k] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 3'b000;

    // Reset state.
    @(negedge clk);
    check("a.rst_in_ready", 32'(in_ready[0]), 32'h1);
    check("a.rst_out_valid", 32'(out_valid[0]), 32'h0);
    check("a.rst_out_byte", 32'(out_byte[0]), 32'h0);
    check("a.rst_count", 32'(mc[0]), 32'h0);

    // Pin the model to hand-written messages.
    check_str("model.result", expect_msg(4, 2, 0, 1, 32'h1A3F, 16'h0), {"Result: 1A3F", crlf_s});
    check_str("model.sz_b0", expect_msg(4, 2, 1, 1, 32'h00B0, 16'h0), {"Result: B0", crlf_s});
    check_str("model.err13", expect_msg(8, 5, 0, 0, 32'h0, 16'h13), {"Error: 13!", lf_s});

    // Default instance.
    vcnt[0] = 0;
    run_msg(0, 32'h1A3F, 16'h0, {"Result: 1A3F", crlf_s});
    check("a.valid_cycles", 32'(vcnt[0]), 32'd14);
    run_msg(0, 32'hFFFF, 16'h2, {"Error: 2!", crlf_s});
    run_msg(0, 32'h0000, 16'h3, {"Error: 3!", crlf_s});
    run_msg(0, 32'h0000, 16'h0, {"Result: 0000", crlf_s});
    @(posedge clk); #1;
    check("a.count4", 32'(mc[0]), 32'd4);

    // Random stalls.
    rmode[0] = 1;
    run_msg(0, 32'h1A3F, 16'h0, {"Result: 1A3F", crlf_s});
    rmode[0] = 0;
    run_msg(0, 32'hC0DE, 16'h0, {"Result: C0DE", crlf_s});

    // Reset after the 5th byte handshake.
    rx[0] = "";
    start_req(0, 32'h1A3F, 16'h0);
    got5 = 0;
    for (int i = 0; i < 100 && !got5; i++) begin
      @(posedge clk); #1;
      if (rx[0].len() >= 5) got5 = 1;
    end
    check("a.reached_5", 32'(got5), 32'h1);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    check("a.abort_valid", 32'(out_valid[0]), 32'h0);
    check("a.abort_count", 32'(mc[0]), 32'h0);
    check("a.abort_bytes", 32'(rx[0].len()), 32'd5);
    run_msg(0, 32'h1A3F, 16'h0, {"Result: 1A3F", crlf_s});
    @(posedge clk); #1;
    check("a.count_after_abort", 32'(mc[0]), 32'd1);

    // Leading-zero suppression.
    run_msg(1, 32'h0000, 16'h0, {"Result: 0", crlf_s});
    run_msg(1, 32'h00B0, 16'h0, {"Result: B0", crlf_s});
    run_msg(1, 32'h0001, 16'h0, {"Result: 1", crlf_s});
    run_msg(1, 32'h1000, 16'h0, {"Result: 1000", crlf_s});
    run_msg(1, 32'h0000, 16'h1, {"Error: 1!", crlf_s});

    // Wide result, 5-bit error, LF-only terminator.
    run_msg(2, 32'h0, 16'h13, {"Error: 13!", lf_s});
    run_msg(2, 32'h89ABCDEF, 16'h0, {"Result: 89ABCDEF", lf_s});
    run_msg(2, 32'h000000F0, 16'h01, {"Error: 01!", lf_s});

    // Counter wrap: preload near the top instead of sending 65535 messages.
    @(posedge clk);
    @(negedge clk); #1;
    force u_dut_c.msg_count = 16'hFFFE;
    cnt[2] = 16'hFFFE;
    #1 release u_dut_c.msg_count;
    run_msg(2, 32'h0, 16'h13, {"Error: 13!", lf_s});
    run_msg(2, 32'h0, 16'h13, {"Error: 13!", lf_s});
    @(posedge clk); #1;
    check("c.wrap_count", 32'(mc[2]), 32'h0);
    run_msg(2, 32'h0, 16'h13, {"Error: 13!", lf_s});
    @(posedge clk); #1;
    check("c.after_wrap", 32'(mc[2]), 32'h1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
